div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 119 +++++++++++
 tb/tb_div.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// 32-bit restoring divider with a four-state controller (free, divide-by-zero, on, end).
// Result is {remainder, quotient} with sign correction for two's-complement operands.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [31:0] quo, rem, dvs;
  logic        neg_q, neg_r;

  logic        req;
  logic [31:0] abs1, abs2;
  logic [32:0] partial, diff;
  logic        take, last;
  logic [31:0] rem_step, quo_step, rem_fix, quo_fix;

  always_comb begin
    req      = start_i && !annul_i;
    abs1     = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    abs2     = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    // 33-bit partial remainder: the shifted-out MSB must take part in the compare
    partial  = {rem, quo[31]};
    diff     = partial - {1'b0, dvs};
    take     = (partial >= {1'b0, dvs});
    rem_step = take ? diff[31:0] : partial[31:0];
    quo_step = {quo[30:0], take};
    quo_fix  = neg_q ? (~quo_step + 32'd1) : quo_step;
    rem_fix  = neg_r ? (~rem_step + 32'd1) : rem_step;
    last     = (cnt == 6'd31);
  end

  always_comb begin
    state_next = state;
    case (state)
      FREE: begin
        if (req) state_next = (opdata2_i == 32'd0) ? BYZERO : ON;
      end
      BYZERO: state_next = annul_i ? FREE : END;
      ON: begin
        if (annul_i)   state_next = FREE;
        else if (last) state_next = END;
      end
      END: begin
        if (!start_i) state_next = FREE;
      end
      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      dvs      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (req && (opdata2_i != 32'd0)) begin
            quo   <= abs1;
            rem   <= 32'd0;
            dvs   <= abs2;
            cnt   <= 6'd0;
            neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_r <= signed_div_i && opdata1_i[31];
          end
        end
        BYZERO: begin
          ready_o  <= !annul_i;
          result_o <= 64'd0;
        end
        ON: begin
          if (annul_i) begin
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end else begin
            quo <= quo_step;
            rem <= rem_step;
            cnt <= cnt + 6'd1;
            if (last) begin
              result_o <= {rem_fix, quo_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes expected {result, ready edge}, a negedge
// monitor pops and compares whenever ready_o rises.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          edge_no;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_on = 1'b0;
  logic        prev_ready = 1'b0;
  logic [63:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic; signed path via 64-bit ints so -2^31/-1 cannot overflow.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sb2 = longint'({32'd0, b});
    end
    q  = sa / sb2;
    r  = sa % sb2;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (ready_o && !prev_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", {63'd0, ready_o}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", result_o, e.res);
          check("ready_edge", 64'(cyc), 64'(e.edge_no));
        end
        held = result_o;
      end else if (ready_o) begin
        check("result_hold", result_o, held);
      end else begin
        check("result_zero_idle", result_o, 64'd0);
      end
      prev_ready = ready_o;
    end
  end

  task automatic scramble();
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    bit   got;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    e.res        = ref_div(sgn, a, b);
    e.edge_no    = cyc + 1 + ((b == 32'd0) ? 1 : 32);
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      scramble();
    end
    if (!got) check("ready_timeout", 64'd0, 64'd1);
    for (int i = 0; i < hold; i++) begin
      scramble();
      annul_i = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);
    check("ready_drop", {63'd0, ready_o}, 64'd0);
  endtask

  task automatic run_abort(input bit use_rst, input int at_edge);
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd12345;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    repeat (at_edge) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else annul_i = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    annul_i = 1'b0;
    start_i = 1'b0;
    check(use_rst ? "rst_ready" : "annul_ready", {63'd0, ready_o}, 64'd0);
    check(use_rst ? "rst_result" : "annul_result", result_o, 64'd0);
    repeat (40) @(negedge clk);
    check(use_rst ? "rst_never_ready" : "annul_never_ready", {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    mon_on = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 2);
    check("model_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 1);
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, 0);
    run_div(1'b0, 32'd55, 32'd0, 1);
    run_div(1'b1, 32'h80000000, 32'd0, 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1);
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 0);

    run_abort(1'b0, 10);
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, 0);
    run_abort(1'b1, 20);
    run_div(1'b1, 32'hFFFFFF9C, 32'h7, 1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      int sel;
      sel = $urandom_range(0, 7);
      a = (sel == 7) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = a;
        default: b = 32'($urandom);
      endcase
      if (sel == 0) a = 32'($urandom_range(0, 20));
      run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
